edge_event_scheduler: RTL

EDGE_EVENT_SCHEDULER -- requirements
Module: edge_event_scheduler

---
 rtl/edge_event_pkg.sv | 20 ++
 rtl/edge_detect.sv | 33 +++
 rtl/edge_event_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/edge_event_pkg.sv
// Shared definitions for the edge event scheduler.
//
// Contents:
//   N_CH_DEFAULT - default number of monitored channels
//   ch_width()   - channel index width for a given channel count
//   EDGE_FALL    - stored edge type for a falling edge (0)
//   EDGE_RISE    - stored edge type for a rising edge (1)
package edge_event_pkg;

    localparam int unsigned N_CH_DEFAULT = 4;

    localparam logic EDGE_FALL = 1'b0;
    localparam logic EDGE_RISE = 1'b1;

    // Index width is clog2 of the channel count, never below one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Single-channel edge detector: registers the raw level and flags the
// transitions between the previous and the current sample.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset, clears the previous sample
//   a    - raw channel level, synchronous to clk
//   rise - a is high, previous sample low
//   fall - a is low, previous sample high
module edge_detect
    import edge_event_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic rise,
    output logic fall
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= a;
        end
    end

    assign rise = a & ~prev_q;
    assign fall = ~a & prev_q;

endmodule

// File: rtl/edge_event_scheduler.sv
// Edge event scheduler: detects edges on N_CH channels, queues one pending
// event per channel and offers them round-robin over a valid/ready port.
//
// Build option:
//   EDGE_EVENT_FALLING_EN - when defined, falling edges are also events and
//                           evt_rise reports the stored edge type; otherwise
//                           only rising edges are detected and evt_rise
//                           equals evt_valid.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset, clears all state
//   a         - raw channel levels
//   evt_valid - an event is offered
//   evt_ready - consumer accepts the offered event
//   evt_ch    - channel of the offered event
//   evt_rise  - edge type of the offered event (1 rising, 0 falling)
//   ovf       - sticky per-channel overflow flags
//   clr_ovf   - clears all overflow flags
module edge_event_scheduler
    import edge_event_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEFAULT,
    parameter int unsigned CH_W = ch_width(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] a,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_rise,
    output logic [N_CH-1:0] ovf,
    input  logic            clr_ovf
);

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] hit;

    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] ovf_q, ovf_d, ovf_set;
    logic [CH_W-1:0] ptr_q, ptr_d;

    logic [CH_W-1:0] sel;
    logic [CH_W-1:0] hi_sel, lo_sel;
    logic            hi_found;
    logic            xfer;

    for (genvar g = 0; g < N_CH; g++) begin : g_det
        edge_detect u_edge_detect (
            .clk  (clk),
            .rst  (rst),
            .a    (a[g]),
            .rise (rise[g]),
            .fall (fall[g])
        );
    end

`ifdef EDGE_EVENT_FALLING_EN
    logic [N_CH-1:0] etype_q, etype_d;

    assign hit = rise | fall;
`else
    logic unused_fall;

    assign hit         = rise;
    assign unused_fall = ^fall;
`endif

    // Round-robin pick from registered state only: lowest pending channel at
    // or above ptr, else lowest pending channel overall (wrap-around).
    always_comb begin
        hi_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (pending_q[c]) begin
                lo_sel = CH_W'(c);
                if (c >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_sel   = CH_W'(c);
                end
            end
        end
        sel = hi_found ? hi_sel : lo_sel;
    end

    assign evt_valid = |pending_q;
    assign evt_ch    = sel;
    assign xfer      = evt_valid & evt_ready;
    assign ovf       = ovf_q;

`ifdef EDGE_EVENT_FALLING_EN
    assign evt_rise = evt_valid & etype_q[sel];
`else
    assign evt_rise = evt_valid;
`endif

    always_comb begin
        pending_d = pending_q;
        ovf_set   = '0;
`ifdef EDGE_EVENT_FALLING_EN
        etype_d   = etype_q;
`endif
        for (int c = 0; c < N_CH; c++) begin
            if (xfer && (sel == CH_W'(c))) begin
                // Slot frees this cycle, so a simultaneous edge refills it.
                pending_d[c] = hit[c];
`ifdef EDGE_EVENT_FALLING_EN
                if (hit[c]) begin
                    etype_d[c] = rise[c] ? EDGE_RISE : EDGE_FALL;
                end
`endif
            end else if (hit[c]) begin
                if (pending_q[c]) begin
                    // Slot occupied: keep the older event, flag the loss.
                    ovf_set[c] = 1'b1;
                end else begin
                    pending_d[c] = 1'b1;
`ifdef EDGE_EVENT_FALLING_EN
                    etype_d[c]   = rise[c] ? EDGE_RISE : EDGE_FALL;
`endif
                end
            end
        end

        // A new overflow wins over a simultaneous clear.
        ovf_d = (clr_ovf ? '0 : ovf_q) | ovf_set;

        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (sel == CH_W'(N_CH - 1)) ? '0 : sel + CH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            ovf_q     <= '0;
            ptr_q     <= '0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef EDGE_EVENT_FALLING_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            etype_q <= '0;
        end else begin
            etype_q <= etype_d;
        end
    end
`endif

endmodule
